// File: rtl/mont_exit.sv
// mont_exit: converts a 256-bit value out of the Montgomery domain,
// computing outdata = indata * 2^-(WORD*NWORDS) mod modulos. It uses
// word-serial Montgomery reduction and retires one WORD-bit digit per cycle.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   start     single-cycle request, sampled only while idle
//   indata    value in Montgomery form (must be < modulos)
//   modulos   odd modulus n
//   mp        -n^-1 mod 2^WORD
//   busy      high while a conversion is in progress
//   outdata   normal-form result, held until the next completion
//   end_flag  one-cycle pulse when outdata is updated
//   range_err (only with MONT_EXIT_RANGE_CHECK_EN) set on completion when
//             indata >= modulos was rejected at start
//
// Optional feature macro: MONT_EXIT_RANGE_CHECK_EN
module mont_exit #(
  parameter int WORD   = 32,
  parameter int NWORDS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [WORD*NWORDS-1:0] indata,
  input  logic [WORD*NWORDS-1:0] modulos,
  input  logic [WORD-1:0]        mp,
  output logic                   busy,
  output logic [WORD*NWORDS-1:0] outdata,
`ifdef MONT_EXIT_RANGE_CHECK_EN
  output logic                   range_err,
`endif
  output logic                   end_flag
);

  localparam int W  = WORD * NWORDS;
  // Accumulator width: t stays below 2n, and t + q*n < 2^(W+WORD+1).
  localparam int TW = W + WORD + 1;
  localparam int CW = $clog2(NWORDS + 1);

  typedef enum logic [1:0] {IDLE, REDUCE, FINAL} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [TW-1:0]   t_q;
  logic [W-1:0]    n_q;
  logic [WORD-1:0] m_q;
  logic [W-1:0]    outdata_q;
  logic            busy_q;
  logic            end_q;
  logic            rc_q;
  logic            range_err_q;

  logic [WORD-1:0]   q_d;
  logic [W+WORD-1:0] qn_d;
  logic [TW-1:0]     sum_d;
  logic [TW-1:0]     t_d;
  logic [TW-1:0]     n_ext_d;
  logic [W-1:0]      fin_d;
  logic              in_range_bad_d;

  // Low WORD bits of a WORD x WORD product.
  function automatic logic [WORD-1:0] mul_lo(input logic [WORD-1:0] a,
                                             input logic [WORD-1:0] b);
    return a * b;
  endfunction

  // Conditional final subtraction, truncated to the operand width.
  function automatic logic [W-1:0] final_sub(input logic [TW-1:0] t,
                                             input logic [TW-1:0] n);
    logic [TW-1:0] r;
    r = (t >= n) ? (t - n) : t;
    return r[W-1:0];
  endfunction

  always_comb begin
    q_d     = mul_lo(t_q[WORD-1:0], m_q);
    qn_d    = {{W{1'b0}}, q_d} * {{WORD{1'b0}}, n_q};
    // Full-width sum before the shift; its low WORD bits are zero by construction.
    sum_d   = t_q + {1'b0, qn_d};
    t_d     = sum_d >> WORD;
    n_ext_d = {{(WORD+1){1'b0}}, n_q};
    fin_d   = final_sub(t_q, n_ext_d);
`ifdef MONT_EXIT_RANGE_CHECK_EN
    in_range_bad_d = (indata >= modulos);
`else
    in_range_bad_d = 1'b0;
`endif
  end

  // Operand latches: loaded only on an accepted start.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      n_q <= modulos;
      m_q <= mp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      t_q         <= '0;
      outdata_q   <= '0;
      busy_q      <= 1'b0;
      end_q       <= 1'b0;
      rc_q        <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      end_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            t_q    <= {{(WORD+1){1'b0}}, indata};
            cnt_q  <= '0;
            busy_q <= 1'b1;
            rc_q   <= in_range_bad_d;
            // Out-of-range operands skip reduction entirely.
            state_q <= in_range_bad_d ? FINAL : REDUCE;
          end
        end
        REDUCE: begin
          t_q   <= t_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(NWORDS - 1)) state_q <= FINAL;
        end
        FINAL: begin
          outdata_q   <= rc_q ? '0 : fin_d;
          range_err_q <= rc_q;
          end_q       <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = busy_q;
  assign outdata  = outdata_q;
  assign end_flag = end_q;
`ifdef MONT_EXIT_RANGE_CHECK_EN
  assign range_err = range_err_q;
`else
  logic unused_rc;
  assign unused_rc = range_err_q ^ in_range_bad_d;
`endif

endmodule

// File: tb/tb_mont_exit.sv
// Self-checking bench for mont_exit. The reference result is computed by
// repeated modular halving (x*2^-256 mod n, one bit at a time) and confirmed
// with a 512-bit (out * 2^256) mod n == in identity.
module tb_mont_exit;
  localparam int W = 256;
  localparam logic [W-1:0]  NPROD  = 256'h2523648240000001ba344d80000000086121000000000013a700000000000013;
  localparam logic [31:0]   MPPROD = 32'hd79435e5;
  localparam logic [W-1:0]  NID    = {W{1'b1}};

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  indata, modulos;
  logic [31:0]   mp;
  logic          busy, end_flag;
  logic [W-1:0]  outdata;
`ifdef MONT_EXIT_RANGE_CHECK_EN
  logic          range_err;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mont_exit #(.WORD(32), .NWORDS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .indata(indata), .modulos(modulos),
    .mp(mp), .busy(busy), .outdata(outdata),
`ifdef MONT_EXIT_RANGE_CHECK_EN
    .range_err(range_err),
`endif
    .end_flag(end_flag)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_exit(input logic [W-1:0] x, input logic [W-1:0] n);
    logic [W:0] a;
    a = {1'b0, x};
    for (int i = 0; i < W; i++) begin
      if (a[0]) a = a + {1'b0, n};
      a = a >> 1;
    end
    return a[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Checks both the halving model and the 2^256 back-multiplication identity.
  task automatic check_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] n);
    logic [511:0] p;
    chk({tag, "_ref"}, {256'b0, outdata}, {256'b0, ref_exit(x, n)});
    p = {outdata, 256'b0} % {256'b0, n};
    chk({tag, "_ident"}, p, {256'b0, x});
    chk({tag, "_lt_n"}, {511'b0, (outdata < n)}, 512'd1);
  endtask

  task automatic run_conv(input logic [W-1:0] x, input logic [W-1:0] n, input logic [31:0] m,
                          input bit scramble, output int lat, output int busy_cnt);
    indata = x; modulos = n; mp = m; start = 1'b1;
    tick;
    start = 1'b0;
    lat = 0; busy_cnt = 0;
    while (lat < 40) begin
      if (busy) busy_cnt++;
      if (scramble) begin
        indata = rnd256(); modulos = rnd256(); mp = $urandom;
      end
      tick;
      lat++;
      if (end_flag) break;
    end
  endtask

  initial begin
    int lat, bc, flags;
    logic [W-1:0] x, x2;

    rst = 1'b1; start = 1'b0; indata = '0; modulos = '0; mp = '0;
    tick; tick;
    chk("rst_busy", {511'b0, busy}, 512'd0);
    chk("rst_end", {511'b0, end_flag}, 512'd0);
    chk("rst_out", {256'b0, outdata}, 512'd0);
    rst = 1'b0;
    tick;

    // Identity modulus: R mod n == 1, so the result equals the input.
    x = 256'h0123456789abcdef0123456789abcdef0123456789abcdef0123456789abcdef;
    run_conv(x, NID, 32'h00000001, 1'b0, lat, bc);
    chk("id_lat", lat, 9);
    chk("id_busy_cycles", bc, 9);
    chk("id_out", {256'b0, outdata}, {256'b0, x});
    chk("id_busy_low", {511'b0, busy}, 512'd0);
    tick;
    chk("id_end_clears", {511'b0, end_flag}, 512'd0);
    chk("id_out_hold", {256'b0, outdata}, {256'b0, x});

    run_conv('0, NPROD, MPPROD, 1'b0, lat, bc);
    chk("zero_lat", lat, 9);
    chk("zero_out", {256'b0, outdata}, 512'd0);

    run_conv(NPROD - 1, NPROD, MPPROD, 1'b0, lat, bc);
    chk("nm1_lat", lat, 9);
    check_result("nm1", NPROD - 1, NPROD);

    for (int i = 0; i < 20; i++) begin
      x = rnd256() % NPROD;
      run_conv(x, NPROD, MPPROD, 1'b0, lat, bc);
      chk($sformatf("rnd%0d_lat", i), lat, 9);
      check_result($sformatf("rnd%0d", i), x, NPROD);
    end

    // Starts at E0, E3 (busy) and on the end_flag edge: one completion only.
    x = rnd256() % NPROD;
    indata = x; modulos = NPROD; mp = MPPROD; start = 1'b1;
    tick; start = 1'b0;
    tick; tick;
    start = 1'b1; tick; start = 1'b0;
    chk("b2b_busy_E3", {511'b0, busy}, 512'd1);
    flags = 0;
    for (int i = 0; i < 5; i++) begin tick; flags += int'(end_flag); end
    start = 1'b1; tick; start = 1'b0;
    chk("b2b_end_E9", {511'b0, end_flag}, 512'd1);
    flags += int'(end_flag);
    for (int i = 0; i < 12; i++) begin tick; flags += int'(end_flag); end
    chk("b2b_one_end", flags, 1);
    chk("b2b_out", {256'b0, outdata}, {256'b0, ref_exit(x, NPROD)});

    // Start in the cycle after end_flag is accepted.
    x = rnd256() % NPROD;
    x2 = rnd256() % NPROD;
    run_conv(x, NPROD, MPPROD, 1'b0, lat, bc);
    check_result("bb1", x, NPROD);
    run_conv(x2, NPROD, MPPROD, 1'b0, lat, bc);
    chk("bb2_lat", lat, 9);
    check_result("bb2", x2, NPROD);

    // Reset during iteration 4 abandons the conversion.
    indata = rnd256() % NPROD; modulos = NPROD; mp = MPPROD; start = 1'b1;
    tick; start = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rst = 1'b1; tick; rst = 1'b0;
    chk("mid_rst_busy", {511'b0, busy}, 512'd0);
    chk("mid_rst_out", {256'b0, outdata}, 512'd0);
    flags = int'(end_flag);
    for (int i = 0; i < 15; i++) begin tick; flags += int'(end_flag); end
    chk("mid_rst_no_end", flags, 0);
    x = rnd256() % NPROD;
    run_conv(x, NPROD, MPPROD, 1'b0, lat, bc);
    chk("post_rst_lat", lat, 9);
    check_result("post_rst", x, NPROD);

    // Operands scrambled every busy cycle.
    x = rnd256() % NPROD;
    run_conv(x, NPROD, MPPROD, 1'b1, lat, bc);
    chk("stab_lat", lat, 9);
    check_result("stab", x, NPROD);

`ifdef MONT_EXIT_RANGE_CHECK_EN
    run_conv(NPROD, NPROD, MPPROD, 1'b0, lat, bc);
    chk("rc_lat", lat, 1);
    chk("rc_out", {256'b0, outdata}, 512'd0);
    chk("rc_err", {511'b0, range_err}, 512'd1);
    x = rnd256() % NPROD;
    run_conv(x, NPROD, MPPROD, 1'b0, lat, bc);
    chk("rc_valid_lat", lat, 9);
    chk("rc_valid_err", {511'b0, range_err}, 512'd0);
    check_result("rc_valid", x, NPROD);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
